// File: rtl/branch_pkg.sv
// Shared types for the branch controller: opcode enum, flag bit indices,
// and a helper that identifies conditional (statically not-taken) ops.
package branch_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BR   = 4'd1,
        BR_BLTZ = 4'd2,
        BR_BZ   = 4'd3,
        BR_BNZ  = 4'd4,
        BR_B    = 4'd5,
        BR_BCY  = 4'd6,
        BR_BNCY = 4'd7,
        BR_BL   = 4'd8,
        BR_RET  = 4'd9
    } br_op_t;

    // Bit positions inside the {N,Z,C} flag register
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_cond_op(input logic [3:0] op);
        return (op == BR_BLTZ) || (op == BR_BZ) || (op == BR_BNZ) ||
               (op == BR_BCY)  || (op == BR_BNCY);
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; the caller never asserts push and pop together.
module branch_ras
    import branch_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(RAS_DEPTH))
                count_d = count_q + CNT_W'(1);
        end else if (pop) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[ptr_q] <= push_data;
    end

    assign top   = mem_q[ptr_q - PTR_W'(1)];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/branch_ctrl_unit.sv
// PC / branch controller: flag register, branch resolution, RAS and link.
// Define BRANCH_STATS_EN to add taken_cnt / mispredict_cnt output counters.
module branch_ctrl_unit
    import branch_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [3:0]        br_op,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [ADDR_W-1:0] target,
    input  logic              flag_we,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic [ADDR_W-1:0] pc,
    output logic              redirect,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic [2:0]        flags,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       taken_cnt,
    output logic [31:0]       mispredict_cnt
`endif
);

    logic [ADDR_W-1:0] pc_q, pc_d, link_data_q, link_data_d;
    logic [ADDR_W-1:0] pc_plus1, tgt_pc, ras_top;
    logic [2:0]        flags_q, flags_d;
    logic              redirect_q, redirect_d, link_we_q, link_we_d;
    logic              ras_err_q, ras_err_d;
    logic              taken, ret_underflow, ras_push, ras_pop;

    branch_ras #(.RAS_DEPTH(RAS_DEPTH), .ADDR_W(ADDR_W)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus1),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // NOTE: every variable gets a default first so no path leaves a latch.
    always_comb begin
        pc_plus1      = pc_q + ADDR_W'(1);
        taken         = 1'b0;
        tgt_pc        = target;
        ret_underflow = 1'b0;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        // Conditions read flags_q: a same-cycle flag write is not bypassed.
        case (br_op)
            BR_BR:   begin taken = 1'b1; tgt_pc = rs_value[ADDR_W-1:0]; end
            BR_BLTZ: taken = rs_value[DATA_W-1];
            BR_BZ:   taken = (rs_value == '0);
            BR_BNZ:  taken = (rs_value != '0);
            BR_B:    taken = 1'b1;
            BR_BCY:  taken = flags_q[FLAG_C];
            BR_BNCY: taken = ~flags_q[FLAG_C];
            BR_BL:   begin taken = 1'b1; ras_push = advance; end
            BR_RET: begin
                if (!ras_empty) begin
                    taken   = 1'b1;
                    tgt_pc  = ras_top;
                    ras_pop = advance;
                end else begin
                    ret_underflow = 1'b1;
                end
            end
            default: ;
        endcase

        pc_d        = advance ? (taken ? tgt_pc : pc_plus1) : pc_q;
        redirect_d  = advance & taken;
        link_we_d   = advance & (br_op == BR_BL);
        link_data_d = link_we_d ? pc_plus1 : link_data_q;
        flags_d     = flag_we ? {alu_n, alu_z, alu_c} : flags_q;
        ras_err_d   = ras_err_q | (advance & ret_underflow);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            flags_q     <= '0;
            redirect_q  <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            ras_err_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            redirect_q  <= redirect_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            ras_err_q   <= ras_err_d;
        end
    end

    assign pc        = pc_q;
    assign redirect  = redirect_q;
    assign link_we   = link_we_q;
    assign link_data = link_data_q;
    assign flags     = flags_q;
    assign ras_err   = ras_err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d, mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        taken_cnt_d      = taken_cnt_q + 32'(redirect_d);
        mispredict_cnt_d = mispredict_cnt_q + 32'(redirect_d & is_cond_op(br_op));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q      <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            taken_cnt_q      <= taken_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign taken_cnt      = taken_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Self-checking bench for branch_ctrl_unit: directed scenarios followed by
// random traffic, all compared against a queue-based behavioural model.
module tb_branch_ctrl_unit;
    import branch_pkg::*;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          RAS_DEPTH = 8;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk, rst, advance, flag_we, alu_n, alu_z, alu_c;
    logic [3:0]  br_op;
    logic [31:0] rs_value, target, pc, link_data;
    logic        redirect, link_we, ras_empty, ras_full, ras_err;
    logic [2:0]  flags;
`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt, mispredict_cnt;
`endif

    branch_ctrl_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .advance(advance), .br_op(br_op),
        .rs_value(rs_value), .target(target), .flag_we(flag_we),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
        .pc(pc), .redirect(redirect), .link_we(link_we), .link_data(link_data),
        .flags(flags), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .mispredict_cnt(mispredict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_pc, m_link_data, m_taken_cnt, m_mis_cnt;
    logic [2:0]  m_flags;
    logic        m_redirect, m_link_we, m_err;
    logic [31:0] m_ras[$];

    task automatic model_step();
        logic        tk;
        logic [31:0] nxt, pc1;
        if (rst) begin
            m_pc = RESET_PC; m_flags = '0; m_redirect = 0; m_link_we = 0;
            m_link_data = '0; m_err = 0; m_ras.delete();
            m_taken_cnt = '0; m_mis_cnt = '0;
            return;
        end
        pc1 = m_pc + 32'd1;
        tk  = 1'b0;
        nxt = target;
        if (advance) begin
            case (br_op)
                4'd1: begin tk = 1'b1; nxt = rs_value; end
                4'd2: tk = ($signed(rs_value) < 0);
                4'd3: tk = (rs_value == 32'd0);
                4'd4: tk = (rs_value != 32'd0);
                4'd5: tk = 1'b1;
                4'd6: tk = (m_flags[0] == 1'b1);
                4'd7: tk = (m_flags[0] == 1'b0);
                4'd8: begin
                    tk = 1'b1;
                    m_ras.push_back(pc1);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                    m_link_data = pc1;
                end
                4'd9: begin
                    if (m_ras.size() > 0) begin tk = 1'b1; nxt = m_ras.pop_back(); end
                    else m_err = 1'b1;
                end
                default: ;
            endcase
            m_pc       = tk ? nxt : pc1;
            m_redirect = tk;
            m_link_we  = (br_op == 4'd8);
            if (tk) m_taken_cnt++;
            if (tk && (br_op inside {4'd2, 4'd3, 4'd4, 4'd6, 4'd7})) m_mis_cnt++;
        end else begin
            m_redirect = 1'b0;
            m_link_we  = 1'b0;
        end
        if (flag_we) m_flags = {alu_n, alu_z, alu_c};
    endtask

    task automatic check_all();
        check("pc", pc, m_pc);
        check("flags", 32'(flags), 32'(m_flags));
        check("redirect", 32'(redirect), 32'(m_redirect));
        check("link_we", 32'(link_we), 32'(m_link_we));
        check("link_data", link_data, m_link_data);
        check("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        check("ras_full", 32'(ras_full), 32'(m_ras.size() == RAS_DEPTH));
        check("ras_err", 32'(ras_err), 32'(m_err));
`ifdef BRANCH_STATS_EN
        check("taken_cnt", taken_cnt, m_taken_cnt);
        check("mispredict_cnt", mispredict_cnt, m_mis_cnt);
`endif
    endtask

    task automatic step(input logic r, input logic adv, input logic [3:0] op,
                        input logic [31:0] rs, input logic [31:0] tgt,
                        input logic fwe, input logic [2:0] nzc);
        rst = r; advance = adv; br_op = op; rs_value = rs; target = tgt;
        flag_we = fwe; {alu_n, alu_z, alu_c} = nzc;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rs, op;
        rst = 1; advance = 0; br_op = 0; rs_value = 0; target = 0;
        flag_we = 0; {alu_n, alu_z, alu_c} = 3'b000;
        m_ras.delete();

        for (int i = 0; i < 3; i++) step(1, 0, BR_NONE, 0, 0, 0, 0);
        check("rst_pc", pc, RESET_PC);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_ras_empty", 32'(ras_empty), 32'd1);
        check("rst_redirect", 32'(redirect), 32'd0);

        for (int i = 0; i < 4; i++) step(0, 1, BR_NONE, 0, 0, 0, 0);
        check("none_x4", pc, RESET_PC + 32'd4);

        step(0, 1, BR_BCY, 0, 32'h40, 1, 3'b001);
        check("bcy_old_c", pc, RESET_PC + 32'd5);
        step(0, 1, BR_BCY, 0, 32'h40, 0, 3'b000);
        check("bcy_taken", pc, 32'h40);
        check("bcy_redirect", 32'(redirect), 32'd1);
        step(0, 1, BR_NONE, 0, 0, 0, 0);
        check("redirect_pulse", 32'(redirect), 32'd0);

        step(0, 1, BR_BZ, 32'h0, 32'h80, 0, 0);
        check("bz_taken", pc, 32'h80);
        step(0, 1, BR_BNZ, 32'h0, 32'h90, 0, 0);
        check("bnz_not", pc, 32'h81);
        step(0, 1, BR_BLTZ, 32'h8000_0000, 32'h20, 0, 0);
        check("bltz_taken", pc, 32'h20);
        step(0, 0, BR_BZ, 32'h0, 32'h99, 0, 0);
        check("stall_hold", pc, 32'h20);

        step(0, 1, BR_B, 0, 32'h10, 0, 0);
        step(0, 1, BR_BL, 0, 32'h100, 0, 0);
        check("bl_pc", pc, 32'h100);
        check("bl_link_we", 32'(link_we), 32'd1);
        check("bl_link_data", link_data, 32'h11);
        step(0, 1, BR_RET, 0, 0, 0, 0);
        check("ret_pc", pc, 32'h11);
        check("ret_empty", 32'(ras_empty), 32'd1);

        for (int i = 0; i <= RAS_DEPTH; i++)
            step(0, 1, BR_BL, 0, 32'h200 + 32'(i) * 32'h10, 0, 0);
        check("ras_full", 32'(ras_full), 32'd1);
        for (int i = 0; i < RAS_DEPTH; i++) step(0, 1, BR_RET, 0, 0, 0, 0);
        check("ret_oldest_kept", pc, 32'h201);
        step(0, 1, BR_RET, 0, 0, 0, 0);
        check("ret_underflow_pc", pc, 32'h202);
        check("ret_underflow_err", 32'(ras_err), 32'd1);

        step(0, 1, BR_BL, 0, 32'h300, 0, 0);
        step(1, 1, BR_BL, 0, 32'h400, 0, 0);
        check("rst_bl_pc", pc, RESET_PC);
        check("rst_bl_link_we", 32'(link_we), 32'd0);
        check("rst_bl_empty", 32'(ras_empty), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 32'h0;
                1:       rs = 32'h8000_0000 | $urandom;
                default: rs = $urandom;
            endcase
            op = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(8, 9)) : 32'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, op[3:0], rs,
                 $urandom, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
